hard_mem_1rw_arb_init: RTL
==========================

Name: hard_mem_1rw_arb_init

Overview:
Front-end controller that shares one single-port 1rw SRAM wrapper (e.g. the d512_w64 macro) between two requesters. After reset it zero-fills the whole array, then round-robin arbitrates requests from the two ports. It drives the SRAM's v/w/addr/data pins and captures read data into per-port response registers with a yumi handshake.

Parameters:
width_p, 64, data width of the SRAM word
els_p, 512, number of SRAM entries
init_val_p, 0, value written to every entry during init (width_p bits)
addr_width_lp, $clog2(els_p), address width (local)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
init_done_o  out  1  high once the init sweep completes
req_v_i  in  2  per-port request valid
req_w_i  in  2  per-port write(1)/read(0)
req_addr_i  in  2*addr_width_lp  per-port address; port p at [p*addr_width_lp +: addr_width_lp]
req_data_i  in  2*width_p  per-port write data
req_ready_o  out  2  per-port accept; a request transfers on v&ready
rsp_v_o  out  2  per-port read response valid
rsp_data_o  out  2*width_p  per-port read response data
rsp_yumi_i  in  2  per-port response consume, legal only while rsp_v_o
mem_v_o  out  1  SRAM v_i
mem_w_o  out  1  SRAM w_i
mem_addr_o  out  addr_width_lp  SRAM addr_i
mem_data_o  out  width_p  SRAM data_i
mem_data_i  in  width_p  SRAM data_o; valid the cycle after a read

Behaviour:
- Reset (async assert, sync release): state=INIT, init counter=0, rr pointer=port0-favoured, rsp_v_o=0, rd_pend=0, init_done_o=0, req_ready_o=0. Any reset mid-operation drops pending responses and restarts init.
- INIT: each cycle mem_v_o=1, mem_w_o=1, mem_addr_o=counter, mem_data_o=init_val_p; counter increments. After writing els_p-1 (els_p cycles total) go to RUN; init_done_o=1 from the next cycle onward. req_ready_o=0 throughout INIT.
- RUN eligibility: port p is eligible when req_v_i[p] is high, and, for a read, no read is pending for p (rd_pend for p) and rsp_v_o[p]=0.
- Arbitration: at most one grant per cycle. If only one port is eligible, it wins. If both are eligible, the port not granted last wins, and the pointer updates only on a grant. req_ready_o[p]=1 only for the winner; it depends combinationally on req_v_i/req_w_i.
- Grant drives mem_v_o=1, mem_w_o=req_w_i[p], mem_addr_o and mem_data_o from port p. With no grant, mem_v_o=0 and the other mem outputs are don't-care, but they hold their last value.
- Read in cycle N: rd_pend={1,p} is registered. In N+1, rsp_data_r[p] captures mem_data_i at the edge ending N+1. rsp_v_o[p]=1 from N+2.
- Read-to-response latency is 2 cycles.
- A write in N+1 to the same address does not corrupt the capture, because the pre-write value is latched.
- rsp_v_o[p] clears on the edge where rsp_yumi_i[p]=1.
- Per port, a read accept cannot coincide with a response outstanding. So a new read from p is accepted at the earliest in the cycle after yumi.
- Writes are never blocked by responses. Reads and writes interleave freely across ports.
- Throughput: back-to-back accesses every cycle are allowed, one per cycle total.
- Writes to a port's outstanding-read address are not ordered against the response: the response returns the data at read time.
- Assertions (translate_off): rsp_yumi_i[p] without rsp_v_o[p]; X on req_v_i after init.

Test Plan:
- Init sweep: release reset with els_p=512 → mem_v_o=mem_w_o=1 for exactly 512 cycles, addresses 0..511 in order; init_done_o rises in cycle 513. Then a read of addr 37 returns 0.
- Single port write/read: port0 writes 0xDEAD_BEEF to addr 5, then reads addr 5 → rsp_v_o[0]=1 exactly 2 cycles after the read accept, with rsp_data_o[0]=0xDEAD_BEEF. Yumi the same cycle → rsp_v_o[0] drops next cycle.
- Round-robin: both ports hold v=1 writes for 6 cycles → grants alternate 0,1,0,1,0,1 and the mem address pattern alternates accordingly.
- Backpressure: port1 reads addr 9 and withholds yumi 10 cycles → port1 read ready stays 0 for those cycles. A port1 write and port0 reads are still granted meanwhile. Yumi releases the block.
- Read then same-address write: port0 reads addr 3 (value 0x11) in N; port1 writes 0x22 to addr 3 in N+1 → port0 response =0x11; a later read returns 0x22.
- Reset mid-operation: assert reset_n_i low asynchronously with a response pending and init half done → rsp_v_o and init_done_o go 0 immediately. After release the init sweep restarts from addr 0.

Source files
------------

// File: rtl/hard_mem_1rw_arb_init.sv
// hard_mem_1rw_arb_init: shares one single-port 1rw SRAM between two requesters.
// After reset the whole array is swept with init_val_p. The controller then
// round-robins between the two ports. Read data comes back through per-port
// response registers that are released with a yumi handshake.
module hard_mem_1rw_arb_init #(
  parameter int width_p = 64,
  parameter int els_p = 512,
  parameter logic [width_p-1:0] init_val_p = '0,
  localparam int addr_width_lp = $clog2(els_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  output logic                       init_done_o,
  input  logic [1:0]                 req_v_i,
  input  logic [1:0]                 req_w_i,
  input  logic [2*addr_width_lp-1:0] req_addr_i,
  input  logic [2*width_p-1:0]       req_data_i,
  output logic [1:0]                 req_ready_o,
  output logic [1:0]                 rsp_v_o,
  output logic [2*width_p-1:0]       rsp_data_o,
  input  logic [1:0]                 rsp_yumi_i,
  output logic                       mem_v_o,
  output logic                       mem_w_o,
  output logic [addr_width_lp-1:0]   mem_addr_o,
  output logic [width_p-1:0]         mem_data_o,
  input  logic [width_p-1:0]         mem_data_i
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);

  state_e                    state_r;
  logic [addr_width_lp-1:0]  init_cnt_r;
  logic                      init_done_r;
  logic                      last_gnt_r;   // 1 after reset so port 0 wins the first tie
  logic                      rd_pend_p1;   // a read was issued to the SRAM last cycle
  logic                      rd_port_p1;   // which port that read belongs to
  logic [1:0]                rsp_v_r;
  logic [width_p-1:0]        rsp_data_p2 [2];

  logic                      hold_w_r;
  logic [addr_width_lp-1:0]  hold_addr_r;
  logic [width_p-1:0]        hold_data_r;

  logic [1:0]                elig;
  logic                      gnt_v;
  logic                      gnt_p;
  logic                      sel_w;
  logic [addr_width_lp-1:0]  sel_addr;
  logic [width_p-1:0]        sel_data;

  // Eligibility: writes always go; a read waits until that port has nothing in flight or unconsumed.
  always_comb begin
    elig = 2'b00;
    if (state_r == ST_RUN) begin
      elig[0] = req_v_i[0] & (req_w_i[0] | ~((rd_pend_p1 & ~rd_port_p1) | rsp_v_r[0]));
      elig[1] = req_v_i[1] & (req_w_i[1] | ~((rd_pend_p1 &  rd_port_p1) | rsp_v_r[1]));
    end
  end

  // Round-robin pick of at most one winner, and selection of its request fields.
  always_comb begin
    gnt_v       = |elig;
    gnt_p       = (elig == 2'b11) ? ~last_gnt_r : elig[1];
    sel_w       = gnt_p ? req_w_i[1] : req_w_i[0];
    sel_addr    = gnt_p ? req_addr_i[2*addr_width_lp-1:addr_width_lp]
                        : req_addr_i[addr_width_lp-1:0];
    sel_data    = gnt_p ? req_data_i[2*width_p-1:width_p]
                        : req_data_i[width_p-1:0];
    req_ready_o = 2'b00;
    if (gnt_v) req_ready_o[gnt_p] = 1'b1;
  end

  // SRAM pin drive: the init sweep, the granted request, or the held last value when idle.
  always_comb begin
    mem_v_o    = 1'b0;
    mem_w_o    = hold_w_r;
    mem_addr_o = hold_addr_r;
    mem_data_o = hold_data_r;
    if (state_r == ST_INIT) begin
      mem_v_o    = 1'b1;
      mem_w_o    = 1'b1;
      mem_addr_o = init_cnt_r;
      mem_data_o = init_val_p;
    end else if (gnt_v) begin
      mem_v_o    = 1'b1;
      mem_w_o    = sel_w;
      mem_addr_o = sel_addr;
      mem_data_o = sel_data;
    end
  end

  // Control state: init sweep, arbitration pointer, read tracking and response valids.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r     <= ST_INIT;
      init_cnt_r  <= '0;
      init_done_r <= 1'b0;
      last_gnt_r  <= 1'b1;
      rd_pend_p1  <= 1'b0;
      rd_port_p1  <= 1'b0;
      rsp_v_r     <= 2'b00;
    end else begin
      case (state_r)
        ST_INIT: begin
          init_cnt_r <= init_cnt_r + 1'b1;
          if (init_cnt_r == last_addr_lp) begin
            state_r     <= ST_RUN;
            init_done_r <= 1'b1;
          end
        end
        default: begin
          if (gnt_v) last_gnt_r <= gnt_p;
          // Stage p0 -> p1: remember the read that the SRAM is answering next cycle.
          rd_pend_p1 <= gnt_v & ~sel_w;
          rd_port_p1 <= gnt_p;
          // Stage p1 -> p2: response becomes visible once its data is captured.
          for (int p = 0; p < 2; p++) begin
            if (rsp_yumi_i[p]) rsp_v_r[p] <= 1'b0;
            if (rd_pend_p1 && (rd_port_p1 == 1'(p))) rsp_v_r[p] <= 1'b1;
          end
        end
      endcase
    end
  end

  // Read-data capture: latched the cycle the SRAM presents it, so a following write cannot disturb it.
  always_ff @(posedge clk_i) begin
    if (rd_pend_p1) rsp_data_p2[rd_port_p1] <= mem_data_i;
  end

  // Last driven SRAM pin values, held while no request is granted.
  always_ff @(posedge clk_i) begin
    if (mem_v_o) begin
      hold_w_r    <= mem_w_o;
      hold_addr_r <= mem_addr_o;
      hold_data_r <= mem_data_o;
    end
  end

  assign init_done_o = init_done_r;
  assign rsp_v_o     = rsp_v_r;
  assign rsp_data_o  = {rsp_data_p2[1], rsp_data_p2[0]};

`ifndef SYNTHESIS
  // Protocol checks on the requester side.
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      assert ((rsp_yumi_i & ~rsp_v_r) == 2'b00)
        else $error("rsp_yumi_i asserted without rsp_v_o");
      if (init_done_r) begin
        assert (!$isunknown(req_v_i))
          else $error("req_v_i unknown after init");
      end
    end
  end
`endif

endmodule
